// File: rtl/piso_stream_if.sv
// Load and serial-output bundle for piso_stream: master is the producer/consumer
// side, slave is the serialiser itself.
interface piso_stream_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             msb_first;
  logic             hold;
  logic             out;
  logic             out_valid;
  logic             out_first;
  logic             out_last;

  modport master (
    output in_valid, in_data, msb_first, hold,
    input  in_ready, out, out_valid, out_first, out_last
  );

  modport slave (
    input  in_valid, in_data, msb_first, hold,
    output in_ready, out, out_valid, out_first, out_last
  );
endinterface

// File: rtl/piso_stream.sv
// Parallel-in/serial-out serialiser with valid/ready load, per-word bit order,
// hold stall and first/last framing. Define PISO_PARITY_EN to append an even parity bit.
module piso_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic          clk,
  input logic          reset,
  piso_stream_if.slave bus
);

`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(FRAME - 2);
`ifdef PISO_PARITY_EN
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WIDTH - 1);
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             msb_q, msb_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic in_ready;
  logic accept;
  logic advance;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      msb_q    <= 1'b0;
      out_q    <= 1'b0;
      valid_q  <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      msb_q    <= msb_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      first_q  <= first_d;
      last_q   <= last_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        if (advance) begin
          if (last_q) state_d = accept ? SHIFT : IDLE;
`ifdef PISO_PARITY_EN
          else if (cnt_q == DATA_LAST) state_d = PARITY;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        if (advance) state_d = accept ? SHIFT : IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // The frame's last bit can hand over directly to the next word, so a load
  // may happen from any state; otherwise bits advance only when not held.
  always_comb begin
    in_ready = (state_q == IDLE) || (last_q && !bus.hold);
    accept   = bus.in_valid && in_ready && !reset;
    advance  = (state_q != IDLE) && !bus.hold;

    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    msb_d    = msb_q;
    out_d    = out_q;
    valid_d  = valid_q;
    first_d  = first_q;
    last_d   = last_q;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif

    if (accept) begin
      msb_d    = bus.msb_first;
      shreg_d  = bus.msb_first ? (bus.in_data << 1) : (bus.in_data >> 1);
      out_d    = bus.msb_first ? bus.in_data[WIDTH-1] : bus.in_data[0];
      cnt_d    = '0;
      valid_d  = 1'b1;
      first_d  = 1'b1;
      last_d   = 1'b0;
`ifdef PISO_PARITY_EN
      parity_d = ^bus.in_data;
`endif
    end else if (advance) begin
      if (last_q) begin
        cnt_d   = '0;
        out_d   = 1'b0;
        valid_d = 1'b0;
        first_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        first_d = 1'b0;
        last_d  = (cnt_q == PRE_LAST);
        out_d   = msb_q ? shreg_q[WIDTH-1] : shreg_q[0];
        shreg_d = msb_q ? (shreg_q << 1) : (shreg_q >> 1);
`ifdef PISO_PARITY_EN
        if (cnt_q == DATA_LAST) out_d = parity_q;
`endif
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out       = out_q;
  assign bus.out_valid = valid_q;
  assign bus.out_first = first_q;
  assign bus.out_last  = last_q;

endmodule

// File: doc/piso_stream.md
# piso_stream

Parametrised parallel-in/serial-out serialiser with a valid/ready load handshake, per-word bit order, output stall, and framing flags. It is the next-generation shift-out stage of the datapath: it accepts WIDTH-bit words from an upstream producer and emits them one bit per cycle to a serial link or downstream bit-level consumer. Back-to-back words stream with no idle gap.

## Interface
- WIDTH, default 8: word width in bits; legal range 2..64.
- CNT_W, default $clog2(WIDTH+1): bit-counter width; derived, never overridden.

- clk, input, 1: rising-edge clock, the only clock.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: upstream word present.
- in_ready, output, 1: block can accept a word this cycle.
- in_data, input, WIDTH: parallel word; sampled only on handshake.
- msb_first, input, 1: bit order for the word; sampled only on handshake.
- hold, input, 1: downstream stall; freezes the current bit.
- out, output, 1: serial data bit, registered.
- out_valid, output, 1: out carries a real bit.
- out_first, output, 1: out is the first bit of a frame.
- out_last, output, 1: out is the last bit of a frame.

## Operation
- States: IDLE, SHIFT, plus PARITY when PISO_PARITY_EN is defined.
- Handshake: a word is accepted at a rising edge when in_valid && in_ready && !reset. in_data and msb_first are captured into the shift register and the order flag.
- in_ready is combinational: 1 in IDLE; in SHIFT/PARITY it is 1 only when the final frame bit is presented and hold=0. It is 0 at all other times.
- IDLE -> SHIFT on accept. SHIFT presents bits 0..WIDTH-1 of the frame, in the order set by msb_first: bit WIDTH-1 first when msb_first=1, bit 0 first otherwise.
- At the end of the frame, the state returns to IDLE, or reloads and restarts SHIFT if a new word is accepted on the same edge.
- Bit advance: the shift register and counter advance only on edges where hold=0. While hold=1, out, out_valid, out_first, out_last and in_ready are frozen.
- hold is ignored in IDLE.
- out_first=1 only on frame bit 0. out_last=1 only on the final frame bit.
- IDLE outputs: out=0, out_valid=0, out_first=0, out_last=0.
- The counter counts 0..FRAME-1 and never wraps silently. FRAME = WIDTH, or WIDTH+1 with parity.
- reset in mid-frame aborts the frame immediately. The partial word is discarded and nothing is retransmitted.

## Timing
- Reset values: out=0, out_valid=0, out_first=0, out_last=0, state IDLE. in_ready=1 on the first cycle after reset deasserts. No word is accepted on an edge where reset=1.
- Latency: word accepted at edge k, so the first bit is on out after edge k. The last data bit is on out after edge k+WIDTH-1, assuming no holds.
- Throughput: with in_valid held high and hold=0, one bit every cycle with zero gap. The frame is WIDTH cycles, or WIDTH+1 with parity.
- Each cycle with hold=1 extends the current bit by exactly one cycle.
- Simultaneous events at the last bit:
  - hold=1 wins over the handshake: no accept, in_ready=0.
  - reset=1 wins over everything.

## Configuration
- PISO_PARITY_EN defined: after the WIDTH data bits, the block emits one extra bit in the PARITY state, equal to the even parity (XOR) of the captured word. out_last moves to that bit, and in_ready asserts during the parity bit instead of the last data bit.
- PISO_PARITY_EN undefined: there is no PARITY state, the frame is WIDTH bits, and out_last is on data bit WIDTH-1.

## Test plan
- Reset mid-frame: WIDTH=8, load 8'hA5, assert reset on the 4th bit. Outputs go to 0/0/0/0 on the next edge, and in_ready=1 after release.
- LSB-first: load 8'hA5 with msb_first=0, hold=0. Required out sequence is 1,0,1,0,0,1,0,1, with out_first on the 1st bit and out_last on the 8th.
- MSB-first back-to-back: in_valid held high, words 8'h81 then 8'h3C with msb_first=1. Required: 1,0,0,0,0,0,0,1,0,0,1,1,1,1,0,0 over 16 consecutive cycles, with out_valid never dropping.
- Stall: load 8'hF0 LSB-first and assert hold for 3 cycles during the 2nd bit. That bit (0) is held 4 cycles, flags are frozen, and the total frame is 11 cycles.
- Last-bit conflict: hold=1 and in_valid=1 while the final bit is on out. in_ready stays 0 and no load occurs. Release hold: the load happens on the next edge.
- Parity (PISO_PARITY_EN): load 8'h07, LSB-first. A 9-bit frame of 1,1,1,0,0,0,0,0 then parity 1, with out_last only on the 9th bit.
